// File: rtl/red_blob_locator_if.sv
// Pixel-stream inputs and per-frame object report exchanged with red_blob_locator.
// The master side drives the raster stream; the slave side is the locator.
interface red_blob_locator_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic          red_pixel;
  logic [XW-1:0] x_cont;
  logic [YW-1:0] y_cont;
  logic          h_sync;
  logic          v_sync;
  logic [XW-1:0] obj_x;
  logic [YW-1:0] obj_y;
  logic [XW-1:0] obj_w;
  logic [YW-1:0] obj_h;
  logic          obj_valid;
  logic          frame_done;

  modport master (
    output red_pixel, x_cont, y_cont, h_sync, v_sync,
    input  obj_x, obj_y, obj_w, obj_h, obj_valid, frame_done
  );

  modport slave (
    input  red_pixel, x_cont, y_cont, h_sync, v_sync,
    output obj_x, obj_y, obj_w, obj_h, obj_valid, frame_done
  );
endinterface

// File: rtl/red_blob_locator.sv
// Finds the longest gap-tolerant red run per frame plus the vertical span of qualifying
// lines, and publishes a centre/size/valid report once per frame with a short hold.
module red_blob_locator #(
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int MIN_RUN     = 4,
  parameter int GAP_TOL     = 1,
  parameter int HOLD_FRAMES = 3,
  parameter int DEFAULT_X   = 320,
  parameter int DEFAULT_Y   = 240
) (
  input logic               VGA_clock,
  input logic               reset,
  red_blob_locator_if.slave bus
);
  localparam int            MW        = $clog2(HOLD_FRAMES + 2);
  localparam logic [XW-1:0] ZX        = {XW{1'b0}};
  localparam logic [YW-1:0] ZY        = {YW{1'b0}};
  localparam logic [XW-1:0] RUN_MAX   = {XW{1'b1}};
  localparam logic [XW-1:0] MIN_RUN_V = XW'(MIN_RUN);
  localparam logic [XW-1:0] GAP_TOL_V = XW'(GAP_TOL);
  localparam logic [MW-1:0] HOLD_V    = MW'(HOLD_FRAMES);
  localparam logic [XW-1:0] DEF_X     = XW'(DEFAULT_X);
  localparam logic [YW-1:0] DEF_Y     = YW'(DEFAULT_Y);

  typedef enum logic [1:0] {
    START_UP = 2'd0,
    WAIT     = 2'd1,
    ACTIVE   = 2'd2,
    PUBLISH  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [XW-1:0] run_len_r, gap_cnt_r, run_start_r, max_len_r, max_start_r;
  logic          found_r, line_hit_r;
  logic [YW-1:0] top_r, bottom_r;
  logic [MW-1:0] miss_cnt_r;
  logic [XW-1:0] obj_x_r, obj_w_r;
  logic [YW-1:0] obj_y_r, obj_h_r;
  logic          obj_valid_r, frame_done_r;

  logic [XW:0]   run_sum_s;
  logic [XW-1:0] run_next_s;
  logic [YW-1:0] span_s;
  logic          scan_s, line_end_s;

  // Bridged gap pixels are folded into the run length when red resumes; length saturates
  assign run_sum_s  = {1'b0, run_len_r} + {1'b0, gap_cnt_r} + {{XW{1'b0}}, 1'b1};
  assign run_next_s = run_sum_s[XW] ? RUN_MAX : run_sum_s[XW-1:0];
  assign span_s     = bottom_r - top_r;
  assign scan_s     = (state_r == WAIT) || (state_r == ACTIVE);
  assign line_end_s = (state_r == ACTIVE) && !bus.h_sync;

  // State register
  always_ff @(posedge VGA_clock or negedge reset) begin
    if (!reset) state_r <= START_UP;
    else        state_r <= state_s;
  end

  // Next-state decode; a frame end seen mid-line waits until the line has closed
  always_comb begin
    state_s = state_r;
    case (state_r)
      START_UP: if (bus.v_sync) state_s = WAIT; else state_s = START_UP;
      WAIT: begin
        if (!bus.v_sync)     state_s = PUBLISH;
        else if (bus.h_sync) state_s = ACTIVE;
        else                 state_s = WAIT;
      end
      ACTIVE:   if (!bus.h_sync) state_s = WAIT; else state_s = ACTIVE;
      PUBLISH:  state_s = START_UP;
      default:  state_s = START_UP;
    endcase
  end

  // Run detection, frame-wide longest-run record and vertical extent of qualifying lines
  always_ff @(posedge VGA_clock or negedge reset) begin
    if (!reset) begin
      run_len_r   <= ZX;
      gap_cnt_r   <= ZX;
      run_start_r <= ZX;
      max_len_r   <= ZX;
      max_start_r <= ZX;
      found_r     <= 1'b0;
      line_hit_r  <= 1'b0;
      top_r       <= ZY;
      bottom_r    <= ZY;
    end else begin
      case (state_r)
        START_UP: begin
          run_len_r   <= ZX;
          gap_cnt_r   <= ZX;
          max_len_r   <= ZX;
          max_start_r <= ZX;
          found_r     <= 1'b0;
          line_hit_r  <= 1'b0;
        end
        WAIT: begin
          run_len_r <= ZX;
          gap_cnt_r <= ZX;
        end
        ACTIVE: begin
          if (bus.h_sync) begin
            if (bus.red_pixel) begin
              if (run_len_r == ZX) run_start_r <= bus.x_cont;
              run_len_r <= run_next_s;
              gap_cnt_r <= ZX;
            end else if ((run_len_r != ZX) && (gap_cnt_r < GAP_TOL_V)) begin
              gap_cnt_r <= gap_cnt_r + XW'(1);
            end else begin
              run_len_r <= ZX;
              gap_cnt_r <= ZX;
            end
          end
        end
        default: ;
      endcase

      // Strict compare keeps the earliest of equally long runs
      if (scan_s && (run_len_r >= MIN_RUN_V)) begin
        line_hit_r <= 1'b1;
        if (run_len_r > max_len_r) begin
          max_len_r   <= run_len_r;
          max_start_r <= run_start_r;
        end
      end

      if (line_end_s) begin
        if (line_hit_r) begin
          if (!found_r) top_r <= bus.y_cont;
          bottom_r <= bus.y_cont;
          found_r  <= 1'b1;
        end
        line_hit_r <= 1'b0;
      end
    end
  end

  // Frame report: publish on a hit, otherwise hold for a few frames and then fall back
  always_ff @(posedge VGA_clock or negedge reset) begin
    if (!reset) begin
      obj_x_r      <= DEF_X;
      obj_y_r      <= DEF_Y;
      obj_w_r      <= ZX;
      obj_h_r      <= ZY;
      obj_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      miss_cnt_r   <= {MW{1'b0}};
    end else begin
      frame_done_r <= (state_r == PUBLISH);
      if (state_r == PUBLISH) begin
        if (found_r) begin
          obj_x_r     <= max_start_r + (max_len_r >> 1);
          obj_y_r     <= top_r + (span_s >> 1);
          obj_w_r     <= max_len_r;
          obj_h_r     <= span_s + YW'(1);
          obj_valid_r <= 1'b1;
          miss_cnt_r  <= {MW{1'b0}};
        end else begin
          obj_valid_r <= 1'b0;
          if (miss_cnt_r < HOLD_V) begin
            miss_cnt_r <= miss_cnt_r + MW'(1);
          end else begin
            obj_x_r <= DEF_X;
            obj_y_r <= DEF_Y;
            obj_w_r <= ZX;
            obj_h_r <= ZY;
          end
        end
      end
    end
  end

  assign bus.obj_x      = obj_x_r;
  assign bus.obj_y      = obj_y_r;
  assign bus.obj_w      = obj_w_r;
  assign bus.obj_h      = obj_h_r;
  assign bus.obj_valid  = obj_valid_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_red_blob_locator.sv
// Directed and random frames for red_blob_locator, checked against a run-list model of
// each frame that derives the expected report directly from the painted image.
module tb_red_blob_locator;
  localparam int XW = 10, YW = 9, MIN_RUN = 4, GAP_TOL = 1, HOLD_FRAMES = 3;
  localparam int DEFAULT_X = 320, DEFAULT_Y = 240;
  localparam int NX = 240, NL_MAX = 16, BLANK = 3;

  logic VGA_clock = 1'b0;
  logic reset;

  red_blob_locator_if #(.XW(XW), .YW(YW)) bus ();

  red_blob_locator #(
    .XW(XW), .YW(YW), .MIN_RUN(MIN_RUN), .GAP_TOL(GAP_TOL), .HOLD_FRAMES(HOLD_FRAMES),
    .DEFAULT_X(DEFAULT_X), .DEFAULT_Y(DEFAULT_Y)
  ) dut (
    .VGA_clock(VGA_clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 VGA_clock = ~VGA_clock;

  bit img [0:NL_MAX-1][0:NX-1];
  int n_checks = 0;
  int n_fails = 0;
  int exp_x, exp_y, exp_w, exp_h, exp_valid, miss;
  int pulses;
  logic [31:0] cap_x, cap_y, cap_w, cap_h, cap_v;

  task automatic step();
    @(posedge VGA_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_img();
    for (int l = 0; l < NL_MAX; l++)
      for (int x = 0; x < NX; x++) img[l][x] = 1'b0;
  endtask

  task automatic paint(input int l, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) img[l][x] = 1'b1;
  endtask

  task automatic model_reset();
    exp_x = DEFAULT_X; exp_y = DEFAULT_Y; exp_w = 0; exp_h = 0; exp_valid = 0; miss = 0;
  endtask

  // Split each line into gap-bridged runs, then apply the frame-level selection rules
  task automatic model_frame(input int y_base, input int nl);
    int found, top, bottom, best_len, best_start, len;
    int rs[$];
    int re[$];
    bit hit;
    found = 0; top = 0; bottom = 0; best_len = 0; best_start = 0;
    for (int l = 0; l < nl; l++) begin
      rs.delete(); re.delete(); hit = 1'b0;
      for (int x = 0; x < NX; x++) begin
        if (img[l][x]) begin
          if (re.size() > 0 && (x - re[re.size()-1] - 1) <= GAP_TOL) re[re.size()-1] = x;
          else begin rs.push_back(x); re.push_back(x); end
        end
      end
      for (int k = 0; k < rs.size(); k++) begin
        len = re[k] - rs[k] + 1;
        if (len >= MIN_RUN) begin
          hit = 1'b1;
          if (len > best_len) begin best_len = len; best_start = rs[k]; end
        end
      end
      if (hit) begin
        if (found == 0) top = y_base + l;
        bottom = y_base + l;
        found = 1;
      end
    end
    if (found != 0) begin
      exp_x = (best_start + best_len / 2) % (1 << XW);
      exp_y = (top + (bottom - top) / 2) % (1 << YW);
      exp_w = best_len;
      exp_h = bottom - top + 1;
      exp_valid = 1;
      miss = 0;
    end else begin
      exp_valid = 0;
      if (miss < HOLD_FRAMES) miss++;
      else begin exp_x = DEFAULT_X; exp_y = DEFAULT_Y; exp_w = 0; exp_h = 0; end
    end
  endtask

  task automatic drive_line(input int l, input int y, input int n_px);
    for (int x = 0; x < n_px; x++) begin
      bus.h_sync = 1'b1; bus.x_cont = XW'(x); bus.y_cont = YW'(y); bus.red_pixel = img[l][x];
      step();
    end
  endtask

  task automatic run_frame(input string tag, input int y_base, input int nl);
    bus.v_sync = 1'b1; bus.h_sync = 1'b0; bus.red_pixel = 1'b0;
    repeat (3) step();
    for (int l = 0; l < nl; l++) begin
      drive_line(l, y_base + l, NX);
      for (int b = 0; b < BLANK; b++) begin
        bus.h_sync = 1'b0; bus.red_pixel = 1'($urandom_range(0, 1));
        step();
      end
    end
    bus.v_sync = 1'b0; bus.h_sync = 1'b0; bus.red_pixel = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.frame_done === 1'b1) begin
        pulses++;
        cap_x = 32'(bus.obj_x); cap_y = 32'(bus.obj_y); cap_w = 32'(bus.obj_w);
        cap_h = 32'(bus.obj_h); cap_v = 32'(bus.obj_valid);
      end
    end
    model_frame(y_base, nl);
    chk({tag, ".pulses"}, pulses, 1);
    chk({tag, ".obj_x"}, cap_x, exp_x);
    chk({tag, ".obj_y"}, cap_y, exp_y);
    chk({tag, ".obj_w"}, cap_w, exp_w);
    chk({tag, ".obj_h"}, cap_h, exp_h);
    chk({tag, ".obj_valid"}, cap_v, exp_valid);
  endtask

  task automatic chk_defaults(input string tag);
    chk({tag, ".obj_x"}, 32'(bus.obj_x), DEFAULT_X);
    chk({tag, ".obj_y"}, 32'(bus.obj_y), DEFAULT_Y);
    chk({tag, ".obj_w"}, 32'(bus.obj_w), 0);
    chk({tag, ".obj_h"}, 32'(bus.obj_h), 0);
    chk({tag, ".obj_valid"}, 32'(bus.obj_valid), 0);
    chk({tag, ".frame_done"}, 32'(bus.frame_done), 0);
  endtask

  initial begin
    int p;
    reset = 1'b0;
    bus.red_pixel = 1'b0; bus.x_cont = '0; bus.y_cont = '0; bus.h_sync = 1'b0; bus.v_sync = 1'b0;
    model_reset();
    repeat (3) step();
    chk_defaults("reset");
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.frame_done === 1'b1) pulses++;
    end
    chk("startup.no_publish", pulses, 0);

    clear_img();
    run_frame("empty", 0, 2);

    clear_img();
    for (int l = 2; l <= 11; l++) paint(l, 200, 229);
    run_frame("block", 98, 14);

    clear_img();
    paint(0, 50, 52); paint(0, 54, 60);
    run_frame("gap1", 50, 1);

    clear_img();
    paint(0, 50, 52); paint(0, 55, 61);
    run_frame("gap2", 50, 1);

    clear_img();
    paint(0, 100, 102); paint(2, 30, 37);
    run_frame("minrun_mix", 10, 4);

    clear_img();
    paint(0, 100, 102);
    run_frame("short_only", 20, 1);
    clear_img();
    run_frame("hold2", 0, 2);
    run_frame("hold3", 0, 2);
    run_frame("expire", 0, 2);
    run_frame("stay_default", 0, 2);

    for (int f = 0; f < 6; f++) begin
      clear_img();
      for (int l = 0; l < 12; l++) begin
        case ($urandom_range(0, 3))
          0: p = 0;
          1: p = 35;
          2: p = 75;
          default: p = 97;
        endcase
        for (int x = 4; x < NX - 4; x++) img[l][x] = ($urandom_range(0, 99) < p);
      end
      run_frame($sformatf("rand%0d", f), $urandom_range(0, 480), 12);
    end

    clear_img();
    paint(0, 50, 52); paint(0, 54, 60);
    run_frame("pre_reset", 70, 1);

    // Abort a frame in the middle of a 20-pixel run
    clear_img();
    paint(0, 20, 39);
    bus.v_sync = 1'b1; bus.h_sync = 1'b0;
    repeat (3) step();
    drive_line(0, 30, 30);
    reset = 1'b0;
    #1;
    chk_defaults("midreset");
    bus.h_sync = 1'b0; bus.v_sync = 1'b0; bus.red_pixel = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    model_reset();
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.frame_done === 1'b1) pulses++;
    end
    chk("midreset.no_publish", pulses, 0);

    clear_img();
    for (int l = 0; l < 3; l++) paint(l, 100, 107);
    run_frame("post_reset", 60, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
